axi_lite_dp_ram: RTL
====================

AXI_LITE_DP_RAM -- requirements
Module: axi_lite_dp_ram

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 14, word-address bits (depth 2**MEM_ADDR_WIDTH words of 32 bit).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte base address; bits below MEM_ADDR_WIDTH+2 are ignored.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values are 1 and 2.
REQ-004 SHALL have parameter INIT_FILE, default "", hex image loaded into memory at elaboration; empty means no load.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 {a,b}_axi_awaddr/awprot/awvalid  in  32/3/1; {a,b}_axi_awready  out  1  write address channel, ports A and B.
REQ-008 {a,b}_axi_wdata/wstrb/wvalid  in  32/4/1; {a,b}_axi_wready  out  1  write data channel.
REQ-009 {a,b}_axi_bresp/bvalid  out  2/1; {a,b}_axi_bready  in  1  write response channel.
REQ-010 {a,b}_axi_araddr/arprot/arvalid  in  32/3/1; {a,b}_axi_arready  out  1  read address channel.
REQ-011 {a,b}_axi_rdata/rresp/rvalid  out  32/2/1; {a,b}_axi_rready  in  1  read data channel.

Function
REQ-012 Each port SHALL run an independent FSM with states IDLE, WR_RESP, RD_WAIT, RD_DATA.
REQ-013 In IDLE, a write SHALL be accepted only when awvalid and wvalid are both high: awready and wready pulse high together for exactly that cycle, and the memory is written in that cycle.
REQ-014 After a write is accepted, bvalid SHALL rise on the next cycle (IDLE->WR_RESP) and hold, with bresp stable, until the cycle with bready high; the FSM then returns to IDLE.
REQ-015 In IDLE, arready SHALL pulse high for one cycle to accept a read; rvalid SHALL rise exactly RD_LAT cycles later (RD_LAT=2 passes through RD_WAIT), and rdata/rresp SHALL hold until the cycle with rready high.
REQ-016 When a write (awvalid&wvalid) and a read (arvalid) are both pending in IDLE, the port SHALL serve the type not served last (round-robin flag per port). After reset the flag SHALL give the write priority.
REQ-017 awready/wready/arready SHALL be low in every state other than IDLE; at most one outstanding transaction per port.
REQ-018 Word index SHALL be addr[MEM_ADDR_WIDTH+1:2]; addr[1:0] SHALL be ignored.
REQ-019 If addr[31:MEM_ADDR_WIDTH+2] differs from BASE_ADDR[31:MEM_ADDR_WIDTH+2], the response SHALL be DECERR (2'b11), no write SHALL occur, and rdata SHALL be 0.
REQ-020 In-range accesses SHALL respond OKAY (2'b00).
REQ-021 wstrb bit i SHALL gate byte i; wstrb=0 SHALL leave memory unchanged and respond OKAY.
REQ-022 Same-cycle writes from both ports to the same word SHALL resolve per byte: port A wins on bytes where both strobes are set; all other strobed bytes are written by their own port.
REQ-023 A read and a write to the same word in the same cycle, on the same or different ports, SHALL return the pre-write data (read-first).
REQ-024 awprot/arprot SHALL be ignored.

Reset
REQ-025 On reset both FSMs SHALL go to IDLE; all ready and valid outputs SHALL be 0, bresp/rresp 2'b00, rdata 0, and the priority flags SHALL be reset per REQ-016.
REQ-026 Reset asserted mid-transaction SHALL drop bvalid/rvalid on the next edge and abandon the response; memory contents SHALL be retained across reset.

Structure
REQ-027 The AXI response codes (OKAY, SLVERR, DECERR) and the port FSM state enum SHALL live in the shared package aurora_mem_pkg.
REQ-028 Per-port handshake logic SHALL be one sub-module, axi_lite_ram_port, instantiated twice. The memory array and collision resolution SHALL stay in the top level.

Verification
REQ-029 Write A 0x0000_0010 data 0xDEADBEEF wstrb 4'hF, then read B 0x10 -> bresp 0 one cycle after accept; rdata 0xDEADBEEF, rresp 0, rvalid exactly RD_LAT cycles after arready.
REQ-030 Word 0x20 = 0x11223344; write A wstrb 4'b0101 data 0xAABBCCDD -> read returns 0x11BB33DD.
REQ-031 Same cycle: A writes 0x30 = 0xFFFF0000 with wstrb 4'hC, B writes 0x30 = 0x12345678 with wstrb 4'hF -> word reads 0xFFFF5678.
REQ-032 BASE_ADDR=0x1000_0000, MEM_ADDR_WIDTH=14: read 0x2000_0000 -> rresp 2'b11, rdata 0; write to the same address leaves memory unchanged with bresp 2'b11.
REQ-033 Hold write and read valid continuously on port A for 4 transactions -> service order W,R,W,R; hold bready low 5 cycles -> bvalid/bresp stable, no new ready.
REQ-034 Assert reset while rvalid is high and rready is low -> rvalid 0 on next edge; a later read of the same word returns the previously written data.

Source files
------------

// File: rtl/aurora_mem_pkg.sv
// Shared types for the AXI-Lite dual-port RAM slice.
//   axi_resp_e   : AXI response codes driven on bresp/rresp
//   port_state_e : per-port handshake FSM states
//   addr_in_range: compares the address bits above the RAM window with a base
package aurora_mem_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_RESP,
    ST_RD_WAIT,
    ST_RD_DATA
  } port_state_e;

  // True when addr and base agree on every bit above the word-index field.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned aw);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << (aw + 2);
    return ((addr ^ base) & mask) == '0;
  endfunction

endpackage

// File: rtl/axi_lite_ram_port.sv
// One AXI-Lite slave port of the dual-port RAM: handshake FSM, round-robin
// write/read arbitration, address decode and response generation.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   axi_aw*/w*/b*/ar*/r*  : AXI-Lite slave channels
//   mem_we/widx/wdata/wstrb : write request to the RAM (pulse on accept)
//   mem_re/ridx           : read request to the RAM (pulse on accept)
//   mem_rdata             : registered RAM read word (valid the cycle after mem_re)
module axi_lite_ram_port
  import aurora_mem_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned RD_LAT         = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               axi_awaddr,
  input  logic [2:0]                axi_awprot,
  input  logic                      axi_awvalid,
  output logic                      axi_awready,
  input  logic [31:0]               axi_wdata,
  input  logic [3:0]                axi_wstrb,
  input  logic                      axi_wvalid,
  output logic                      axi_wready,
  output logic [1:0]                axi_bresp,
  output logic                      axi_bvalid,
  input  logic                      axi_bready,
  input  logic [31:0]               axi_araddr,
  input  logic [2:0]                axi_arprot,
  input  logic                      axi_arvalid,
  output logic                      axi_arready,
  output logic [31:0]               axi_rdata,
  output logic [1:0]                axi_rresp,
  output logic                      axi_rvalid,
  input  logic                      axi_rready,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_widx,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_wstrb,
  output logic                      mem_re,
  output logic [MEM_ADDR_WIDTH-1:0] mem_ridx,
  input  logic [31:0]               mem_rdata
);

  port_state_e state, state_n;
  axi_resp_e   bresp_q, rresp_q;
  logic        prefer_wr;
  logic        wr_pend, wr_take, rd_take;
  logic        wr_ok, rd_ok;
  logic [31:0] rdata_q, rdata_raw;
  logic        unused_bits;

  assign wr_ok = addr_in_range(axi_awaddr, BASE_ADDR, MEM_ADDR_WIDTH);
  assign rd_ok = addr_in_range(axi_araddr, BASE_ADDR, MEM_ADDR_WIDTH);

  // Protection bits and byte offset carry no meaning for this RAM.
  assign unused_bits = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};

  always_comb begin
    state_n     = state;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_arready = 1'b0;
    wr_take     = 1'b0;
    rd_take     = 1'b0;
    wr_pend     = axi_awvalid & axi_wvalid;
    case (state)
      ST_IDLE: begin
        if (wr_pend && (!axi_arvalid || prefer_wr)) begin
          axi_awready = 1'b1;
          axi_wready  = 1'b1;
          wr_take     = 1'b1;
          state_n     = ST_WR_RESP;
        end else if (axi_arvalid) begin
          axi_arready = 1'b1;
          rd_take     = 1'b1;
          state_n     = (RD_LAT == 2) ? ST_RD_WAIT : ST_RD_DATA;
        end
      end
      ST_WR_RESP: if (axi_bready) state_n = ST_IDLE;
      ST_RD_WAIT: state_n = ST_RD_DATA;
      ST_RD_DATA: if (axi_rready) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      prefer_wr <= 1'b1;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state <= state_n;
      if (wr_take) begin
        prefer_wr <= 1'b0;
        bresp_q   <= wr_ok ? RESP_OKAY : RESP_DECERR;
      end
      if (rd_take) begin
        prefer_wr <= 1'b1;
        rresp_q   <= rd_ok ? RESP_OKAY : RESP_DECERR;
      end
      // Second read stage: the RAM word arrives during RD_WAIT.
      if (state == ST_RD_WAIT) rdata_q <= mem_rdata;
    end
  end

  assign mem_we    = wr_take & wr_ok & ~reset;
  assign mem_widx  = axi_awaddr[MEM_ADDR_WIDTH+1:2];
  assign mem_wdata = axi_wdata;
  assign mem_wstrb = axi_wstrb;
  assign mem_re    = rd_take & rd_ok & ~reset;
  assign mem_ridx  = axi_araddr[MEM_ADDR_WIDTH+1:2];

  assign axi_bvalid = (state == ST_WR_RESP);
  assign axi_rvalid = (state == ST_RD_DATA);
  assign axi_bresp  = bresp_q;
  assign axi_rresp  = rresp_q;

  // The RAM read register is only loaded for in-range reads, so decode
  // errors and idle cycles force the data bus to zero here.
  assign rdata_raw = (RD_LAT == 2) ? rdata_q : mem_rdata;
  assign axi_rdata = (axi_rvalid && rresp_q == RESP_OKAY) ? rdata_raw : '0;

endmodule

// File: rtl/axi_lite_dp_ram.sv
// Dual-port AXI-Lite RAM: 2**MEM_ADDR_WIDTH x 32-bit words shared by two
// independent AXI-Lite slave ports (A and B), read-first, byte strobes,
// port A wins byte collisions.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   a_axi_*         : AXI-Lite slave port A
//   b_axi_*         : AXI-Lite slave port B
module axi_lite_dp_ram
  import aurora_mem_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned RD_LAT         = 1,
  parameter string       INIT_FILE      = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a_axi_awaddr,
  input  logic [2:0]  a_axi_awprot,
  input  logic        a_axi_awvalid,
  output logic        a_axi_awready,
  input  logic [31:0] a_axi_wdata,
  input  logic [3:0]  a_axi_wstrb,
  input  logic        a_axi_wvalid,
  output logic        a_axi_wready,
  output logic [1:0]  a_axi_bresp,
  output logic        a_axi_bvalid,
  input  logic        a_axi_bready,
  input  logic [31:0] a_axi_araddr,
  input  logic [2:0]  a_axi_arprot,
  input  logic        a_axi_arvalid,
  output logic        a_axi_arready,
  output logic [31:0] a_axi_rdata,
  output logic [1:0]  a_axi_rresp,
  output logic        a_axi_rvalid,
  input  logic        a_axi_rready,
  input  logic [31:0] b_axi_awaddr,
  input  logic [2:0]  b_axi_awprot,
  input  logic        b_axi_awvalid,
  output logic        b_axi_awready,
  input  logic [31:0] b_axi_wdata,
  input  logic [3:0]  b_axi_wstrb,
  input  logic        b_axi_wvalid,
  output logic        b_axi_wready,
  output logic [1:0]  b_axi_bresp,
  output logic        b_axi_bvalid,
  input  logic        b_axi_bready,
  input  logic [31:0] b_axi_araddr,
  input  logic [2:0]  b_axi_arprot,
  input  logic        b_axi_arvalid,
  output logic        b_axi_arready,
  output logic [31:0] b_axi_rdata,
  output logic [1:0]  b_axi_rresp,
  output logic        b_axi_rvalid,
  input  logic        b_axi_rready
);

  localparam int unsigned DEPTH = 2 ** MEM_ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  logic                      a_we, b_we, a_re, b_re;
  logic [MEM_ADDR_WIDTH-1:0] a_widx, b_widx, a_ridx, b_ridx;
  logic [31:0]               a_wdata, b_wdata, a_rd_q, b_rd_q;
  logic [3:0]                a_wstrb, b_wstrb;

  // Both ports update in one block; port A's assignment comes last so it
  // takes any byte both ports strobe in the same cycle.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (b_we && b_wstrb[i]) mem[b_widx][8*i +: 8] <= b_wdata[8*i +: 8];
      if (a_we && a_wstrb[i]) mem[a_widx][8*i +: 8] <= a_wdata[8*i +: 8];
    end
  end

  // Non-blocking reads sample the array before this edge's writes land,
  // giving read-first behaviour on same-word collisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rd_q <= '0;
      b_rd_q <= '0;
    end else begin
      if (a_re) a_rd_q <= mem[a_ridx];
      if (b_re) b_rd_q <= mem[b_ridx];
    end
  end

  axi_lite_ram_port #(
    .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH),
    .BASE_ADDR     (BASE_ADDR),
    .RD_LAT        (RD_LAT)
  ) u_port_a (
    .clk        (clk),
    .reset      (reset),
    .axi_awaddr (a_axi_awaddr),
    .axi_awprot (a_axi_awprot),
    .axi_awvalid(a_axi_awvalid),
    .axi_awready(a_axi_awready),
    .axi_wdata  (a_axi_wdata),
    .axi_wstrb  (a_axi_wstrb),
    .axi_wvalid (a_axi_wvalid),
    .axi_wready (a_axi_wready),
    .axi_bresp  (a_axi_bresp),
    .axi_bvalid (a_axi_bvalid),
    .axi_bready (a_axi_bready),
    .axi_araddr (a_axi_araddr),
    .axi_arprot (a_axi_arprot),
    .axi_arvalid(a_axi_arvalid),
    .axi_arready(a_axi_arready),
    .axi_rdata  (a_axi_rdata),
    .axi_rresp  (a_axi_rresp),
    .axi_rvalid (a_axi_rvalid),
    .axi_rready (a_axi_rready),
    .mem_we     (a_we),
    .mem_widx   (a_widx),
    .mem_wdata  (a_wdata),
    .mem_wstrb  (a_wstrb),
    .mem_re     (a_re),
    .mem_ridx   (a_ridx),
    .mem_rdata  (a_rd_q)
  );

  axi_lite_ram_port #(
    .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH),
    .BASE_ADDR     (BASE_ADDR),
    .RD_LAT        (RD_LAT)
  ) u_port_b (
    .clk        (clk),
    .reset      (reset),
    .axi_awaddr (b_axi_awaddr),
    .axi_awprot (b_axi_awprot),
    .axi_awvalid(b_axi_awvalid),
    .axi_awready(b_axi_awready),
    .axi_wdata  (b_axi_wdata),
    .axi_wstrb  (b_axi_wstrb),
    .axi_wvalid (b_axi_wvalid),
    .axi_wready (b_axi_wready),
    .axi_bresp  (b_axi_bresp),
    .axi_bvalid (b_axi_bvalid),
    .axi_bready (b_axi_bready),
    .axi_araddr (b_axi_araddr),
    .axi_arprot (b_axi_arprot),
    .axi_arvalid(b_axi_arvalid),
    .axi_arready(b_axi_arready),
    .axi_rdata  (b_axi_rdata),
    .axi_rresp  (b_axi_rresp),
    .axi_rvalid (b_axi_rvalid),
    .axi_rready (b_axi_rready),
    .mem_we     (b_we),
    .mem_widx   (b_widx),
    .mem_wdata  (b_wdata),
    .mem_wstrb  (b_wstrb),
    .mem_re     (b_re),
    .mem_ridx   (b_ridx),
    .mem_rdata  (b_rd_q)
  );

endmodule
